// File: rtl/rst_ctrl_pkg.sv
// Shared types for the reset/clock bring-up sequencer.
// Contents: FSM state encoding (matches state_o), reset-cause encoding
// (matches rst_cause_o), retry saturation limit and its increment helper.
package rst_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_PLL_RST   = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } rst_state_e;

  typedef enum logic [2:0] {
    CAUSE_POR          = 3'd0,
    CAUSE_EXT          = 3'd1,
    CAUSE_LOCK_LOSS    = 3'd2,
    CAUSE_SW           = 3'd3,
    CAUSE_LOCK_TIMEOUT = 3'd4,
    CAUSE_WATCHDOG     = 3'd5
  } rst_cause_e;

  localparam logic [3:0] RetryMax = 4'hF;

  function automatic logic [3:0] retry_inc(input logic [3:0] cnt);
    return (cnt == RetryMax) ? cnt : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/rst_debounce.sv
// Two-flop synchroniser plus stability counter for an asynchronous,
// active-low push button.
// Ports:
//   clk_i    clock
//   rst_ni   async active-low reset (synchroniser and level reset to 1)
//   d_i      raw asynchronous input
//   level_o  debounced level
//   fell_o   one-cycle pulse, registered together with the 1->0 change of level_o
module rst_debounce #(
  parameter int unsigned DebounceCycles = 1000,
  parameter int unsigned CntWidth       = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic fell_o
);

  localparam logic [CntWidth-1:0] DbLast = CntWidth'(DebounceCycles - 1);

  logic [1:0]          sync_q;
  logic                level_q, level_d;
  logic                fell_q, fell_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  // Any cycle where the synchronised value agrees with the level clears the
  // count, so a bounce restarts the stability window.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    fell_d  = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == DbLast) begin
        level_d = sync_q[1];
        fell_d  = ~sync_q[1];
      end else begin
        cnt_d = cnt_q + CntWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      fell_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], d_i};
      level_q <= level_d;
      fell_q  <= fell_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign fell_o  = fell_q;

endmodule

// File: rtl/rst_ctrl_sonata.sv
// Board-level reset and clock bring-up sequencer: PLL reset, lock wait with
// timeout/retry, system reset hold window, then RUN with supervision of lock
// loss, reset button, software request and (optionally) a watchdog.
// Optional feature macro: RST_CTRL_WATCHDOG_EN adds parameter WatchdogCycles
// and input wdog_kick_i.
// Ports:
//   clk_sys_i     free-running board clock
//   rst_sys_ni    async active-low power-on reset
//   ext_rst_ni    raw reset button, active-low, asynchronous
//   pll_locked_i  PLL lock, asynchronous
//   sw_rst_req_i  single-cycle software reset request
//   wdog_kick_i   watchdog kick (RST_CTRL_WATCHDOG_EN only)
//   pll_rst_o     PLL reset, active-high
//   rst_sys_no    system reset, active-low
//   state_o       FSM state
//   rst_cause_o   cause of the latest reset entry
//   retry_cnt_o   saturating lock-timeout retry count
//   boot_ok_o     high while in RUN
//
// state      | meaning
// PLL_RST    | PLL held in reset; counter frozen while the button is held
// WAIT_LOCK  | PLL released, waiting for synchronised lock or timeout
// HOLD       | PLL locked, system reset held for the hold window
// RUN        | system reset released, supervising exit events
module rst_ctrl_sonata import rst_ctrl_pkg::*; #(
  parameter int unsigned CntWidth       = 16,
`ifdef RST_CTRL_WATCHDOG_EN
  parameter int unsigned WatchdogCycles = 24'hFF_FFFF,
`endif
  parameter int unsigned PllRstCycles   = 195,
  parameter int unsigned LockTimeout    = 50000,
  parameter int unsigned HoldCycles     = 16,
  parameter int unsigned DebounceCycles = 1000
) (
  input  logic       clk_sys_i,
  input  logic       rst_sys_ni,
  input  logic       ext_rst_ni,
  input  logic       pll_locked_i,
  input  logic       sw_rst_req_i,
`ifdef RST_CTRL_WATCHDOG_EN
  input  logic       wdog_kick_i,
`endif
  output logic       pll_rst_o,
  output logic       rst_sys_no,
  output logic [1:0] state_o,
  output logic [2:0] rst_cause_o,
  output logic [3:0] retry_cnt_o,
  output logic       boot_ok_o
);

  localparam logic [CntWidth-1:0] PllRstLast = CntWidth'(PllRstCycles - 1);
  localparam logic [CntWidth-1:0] LockLast   = CntWidth'(LockTimeout - 1);
  localparam logic [CntWidth-1:0] HoldLast   = CntWidth'(HoldCycles - 1);

  rst_state_e          state_q, state_d;
  rst_cause_e          cause_q, cause_d;
  logic [3:0]          retry_q, retry_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                pll_rst_q, rst_sys_q, boot_ok_q;
  logic [1:0]          lock_sync_q;
  logic                lock_s;
  logic                btn_level, btn_press;
  logic                wdog_expire;

  rst_debounce #(
    .DebounceCycles(DebounceCycles),
    .CntWidth      (CntWidth)
  ) u_btn (
    .clk_i  (clk_sys_i),
    .rst_ni (rst_sys_ni),
    .d_i    (ext_rst_ni),
    .level_o(btn_level),
    .fell_o (btn_press)
  );

  assign lock_s = lock_sync_q[1];

`ifdef RST_CTRL_WATCHDOG_EN
  localparam logic [23:0] WdogLast = 24'(WatchdogCycles - 1);
  logic [23:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d      = '0;
    wdog_expire = 1'b0;
    if (state_q == ST_RUN && !wdog_kick_i) begin
      if (wdog_q == WdogLast) wdog_expire = 1'b1;
      else                    wdog_d      = wdog_q + 24'd1;
    end
  end
`else
  assign wdog_expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_PLL_RST: begin
        if (btn_press)                cnt_d   = '0;
        else if (!btn_level)          cnt_d   = cnt_q;
        else if (cnt_q == PllRstLast) state_d = ST_WAIT_LOCK;
        else                          cnt_d   = cnt_q + CntWidth'(1);
      end
      ST_WAIT_LOCK: begin
        if (btn_press) begin
          state_d = ST_PLL_RST;
          cause_d = CAUSE_EXT;
        end else if (lock_s) begin
          state_d = ST_HOLD;
        end else if (cnt_q == LockLast) begin
          state_d = ST_PLL_RST;
          cause_d = CAUSE_LOCK_TIMEOUT;
          retry_d = retry_inc(retry_q);
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_PLL_RST;
          cause_d = CAUSE_LOCK_LOSS;
        end else if (btn_press) begin
          state_d = ST_PLL_RST;
          cause_d = CAUSE_EXT;
        end else if (cnt_q == HoldLast) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_PLL_RST;
          cause_d = CAUSE_LOCK_LOSS;
        end else if (btn_press) begin
          state_d = ST_PLL_RST;
          cause_d = CAUSE_EXT;
        end else if (wdog_expire) begin
          state_d = ST_HOLD;
          cause_d = CAUSE_WATCHDOG;
        end else if (sw_rst_req_i) begin
          state_d = ST_HOLD;
          cause_d = CAUSE_SW;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state and come straight from flops.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q     <= ST_PLL_RST;
      cause_q     <= CAUSE_POR;
      retry_q     <= '0;
      cnt_q       <= '0;
      pll_rst_q   <= 1'b1;
      rst_sys_q   <= 1'b0;
      boot_ok_q   <= 1'b0;
      lock_sync_q <= 2'b11;
`ifdef RST_CTRL_WATCHDOG_EN
      wdog_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      retry_q     <= retry_d;
      cnt_q       <= cnt_d;
      pll_rst_q   <= (state_d == ST_PLL_RST);
      rst_sys_q   <= (state_d == ST_RUN);
      boot_ok_q   <= (state_d == ST_RUN);
      lock_sync_q <= {lock_sync_q[0], pll_locked_i};
`ifdef RST_CTRL_WATCHDOG_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign rst_sys_no  = rst_sys_q;
  assign state_o     = state_q;
  assign rst_cause_o = cause_q;
  assign retry_cnt_o = retry_q;
  assign boot_ok_o   = boot_ok_q;

endmodule

// File: tb/tb_rst_ctrl_sonata.sv
// Directed bench for rst_ctrl_sonata with an expectation queue: each
// expectation is pushed before its stimulus and popped when the DUT result
// is observed.
module tb_rst_ctrl_sonata;

  localparam int PLL_CYC  = 195;
  localparam int LOCK_TO  = 100;
  localparam int HOLD_CYC = 16;
  localparam int DB_CYC   = 10;
  localparam int WD_CYC   = 50;

  logic       clk = 1'b0;
  logic       rst_n, ext_rst_n, pll_locked, sw_req, wdog_kick;
  logic       pll_rst, rst_sys_n, boot_ok;
  logic [1:0] state;
  logic [2:0] cause;
  logic [3:0] retry;

  always #5 clk = ~clk;

  rst_ctrl_sonata #(
    .CntWidth      (16),
`ifdef RST_CTRL_WATCHDOG_EN
    .WatchdogCycles(WD_CYC),
`endif
    .PllRstCycles  (PLL_CYC),
    .LockTimeout   (LOCK_TO),
    .HoldCycles    (HOLD_CYC),
    .DebounceCycles(DB_CYC)
  ) dut (
    .clk_sys_i   (clk),
    .rst_sys_ni  (rst_n),
    .ext_rst_ni  (ext_rst_n),
    .pll_locked_i(pll_locked),
    .sw_rst_req_i(sw_req),
`ifdef RST_CTRL_WATCHDOG_EN
    .wdog_kick_i (wdog_kick),
`endif
    .pll_rst_o   (pll_rst),
    .rst_sys_no  (rst_sys_n),
    .state_o     (state),
    .rst_cause_o (cause),
    .retry_cnt_o (retry),
    .boot_ok_o   (boot_ok)
  );

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [15:0] st(input logic [1:0] s, input logic [2:0] c,
                                     input logic [3:0] r, input logic p,
                                     input logic rs, input logic b);
    return {4'h0, s, c, r, p, rs, b};
  endfunction

  function automatic logic [15:0] status();
    return {4'h0, state, cause, retry, pll_rst, rst_sys_n, boot_ok};
  endfunction

  task automatic push(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    exp_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
      return;
    end
    e = exp_q.pop_front();
    assert (obs === e.val) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until state_o reaches s; an expired budget returns budget.
  task automatic wait_state(input logic [1:0] s, input int budget,
                            output int n, output logic pll_any);
    n = 0;
    pll_any = 1'b0;
    do begin
      tick();
      n++;
      pll_any |= pll_rst;
    end while (state != s && n < budget);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int   n, incs, first_t, second_t;
    logic pll_any, rs_any, seen_wait;
    logic [3:0] prev;

    rst_n = 1'b0; ext_rst_n = 1'b1; pll_locked = 1'b1; sw_req = 1'b0;
    wdog_kick = 1'b1;
    repeat (3) tick();

    // Reset values
    push("por_reset_values", st(2'd0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0));
    pop_check(status());

    // 1: power-on with lock tied high
    rst_n = 1'b1;
    push("por_pll_rst_cycles", 16'(PLL_CYC));
    wait_state(2'd1, 400, n, pll_any);
    pop_check(16'(n));
    push("por_wait_to_hold", 16'd1);
    wait_state(2'd2, 10, n, pll_any);
    pop_check(16'(n));
    push("por_hold_cycles", 16'(HOLD_CYC));
    wait_state(2'd3, 40, n, pll_any);
    pop_check(16'(n));
    push("por_run_status", st(2'd3, 3'd0, 4'd0, 1'b0, 1'b1, 1'b1));
    pop_check(status());

    // 4: software reset request in RUN
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    push("sw_hold_entry", st(2'd2, 3'd3, 4'd0, 1'b0, 1'b0, 1'b0));
    pop_check(status());
    push("sw_hold_cycles", 16'(HOLD_CYC));
    wait_state(2'd3, 40, n, pll_any);
    pop_check(16'(n));
    push("sw_pll_rst_never", 16'd0);
    pop_check(16'(pll_any));
    push("sw_run_status", st(2'd3, 3'd3, 4'd0, 1'b0, 1'b1, 1'b1));
    pop_check(status());

    // 3: button bounce shorter than the debounce window is ignored
    ext_rst_n = 1'b0; repeat (5) tick(); ext_rst_n = 1'b1; repeat (20) tick();
    push("bounce5_ignored", st(2'd3, 3'd3, 4'd0, 1'b0, 1'b1, 1'b1));
    pop_check(status());
    ext_rst_n = 1'b0; repeat (DB_CYC - 1) tick(); ext_rst_n = 1'b1; repeat (20) tick();
    push("bounce9_ignored", st(2'd3, 3'd3, 4'd0, 1'b0, 1'b1, 1'b1));
    pop_check(status());
    // 2 sync + DB_CYC stable + 1 press register
    ext_rst_n = 1'b0;
    push("press_latency", 16'(2 + DB_CYC + 1));
    wait_state(2'd0, 40, n, pll_any);
    pop_check(16'(n));
    push("press_status", st(2'd0, 3'd1, 4'd0, 1'b1, 1'b0, 1'b0));
    pop_check(status());
    repeat (300) tick();
    push("press_held_stays", st(2'd0, 3'd1, 4'd0, 1'b1, 1'b0, 1'b0));
    pop_check(status());
    ext_rst_n = 1'b1;
    push("release_to_run", 16'(2 + DB_CYC + PLL_CYC + 1 + HOLD_CYC));
    wait_state(2'd3, 600, n, pll_any);
    pop_check(16'(n));
    push("release_run_status", st(2'd3, 3'd1, 4'd0, 1'b0, 1'b1, 1'b1));
    pop_check(status());

    // 5: lock loss and sw request reaching the FSM on the same edge
    pll_locked = 1'b0;
    tick(); tick();
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    push("lockloss_beats_sw", st(2'd0, 3'd2, 4'd0, 1'b1, 1'b0, 1'b0));
    pop_check(status());

    // 2: lock never returns, retries saturate
    incs = 0; first_t = 0; second_t = 0; rs_any = 1'b0; seen_wait = 1'b0;
    prev = retry;
    for (int i = 1; i <= 17 * (PLL_CYC + LOCK_TO) + 100; i++) begin
      tick();
      rs_any    |= rst_sys_n;
      seen_wait |= (state == 2'd1);
      if (retry != prev) begin
        incs++;
        if (incs == 1) first_t = i;
        if (incs == 2) second_t = i;
        prev = retry;
      end
    end
    push("retry_increments", 16'd15);
    pop_check(16'(incs));
    push("retry_period", 16'(PLL_CYC + LOCK_TO));
    pop_check(16'(second_t - first_t));
    push("retry_sat_cause", {9'd0, 3'd4, 4'd15});
    pop_check({9'd0, cause, retry});
    push("retry_rst_sys_low", 16'd0);
    pop_check(16'(rs_any));
    push("retry_wait_seen", 16'd1);
    pop_check(16'(seen_wait));

    // 6: async reset in the middle of HOLD
    pll_locked = 1'b1;
    wait_state(2'd2, 600, n, pll_any);
    push("relock_hold", st(2'd2, 3'd4, 4'd15, 1'b0, 1'b0, 1'b0));
    pop_check(status());
    repeat (5) tick();
    #3 rst_n = 1'b0;
    #1;
    push("async_reset_values", st(2'd0, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0));
    pop_check(status());
    tick();
    rst_n = 1'b1;
    push("reboot_to_run", 16'(PLL_CYC + 1 + HOLD_CYC));
    wait_state(2'd3, 400, n, pll_any);
    pop_check(16'(n));

`ifdef RST_CTRL_WATCHDOG_EN
    wdog_kick = 1'b0;
    push("wdog_cycles", 16'(WD_CYC));
    wait_state(2'd2, 200, n, pll_any);
    pop_check(16'(n));
    push("wdog_status", st(2'd2, 3'd5, 4'd0, 1'b0, 1'b0, 1'b0));
    pop_check(status());
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
